alu_control_md: RTL and testbench

Successor of the single-cycle ALU control decoder for the MIPS datapath. It keeps the ALUOp/function → ALUOperation decode and adds MULT/MULTU/DIV/DIVU with an iterative multiply/divide engine, HI/LO registers, MFHI/MFLO/MTHI/MTLO, and a stall handshake to the pipeline. It sits in EX, beside the ALU, and is fed by the main control unit and the register file read ports.

---
 rtl/alu_ctrl_pkg.sv | 47 ++++
 rtl/md_iter_unit.sv | 127 ++++++++++++
 rtl/alu_control_md.sv | 164 ++++++++++++++++
 tb/tb_alu_control_md.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared codes for the EX-stage ALU control / multiply-divide block:
// ALU opcodes, funct and ALUOp encodings, and the multiply/divide FSM states.
package alu_ctrl_pkg;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_LUI  = 4'b0010;
   localparam logic [3:0] OP_ADD  = 4'b0011;
   localparam logic [3:0] OP_SLL  = 4'b0100;
   localparam logic [3:0] OP_NOR  = 4'b0101;
   localparam logic [3:0] OP_SRL  = 4'b0110;
   localparam logic [3:0] OP_SUB  = 4'b0111;
   localparam logic [3:0] OP_JR   = 4'b1000;
   localparam logic [3:0] OP_NONE = 4'b1001;

   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_NOR   = 6'b100111;
   localparam logic [5:0] FN_SLL   = 6'b000000;
   localparam logic [5:0] FN_SRL   = 6'b000010;
   localparam logic [5:0] FN_JR    = 6'b001000;
   localparam logic [5:0] FN_MULT  = 6'b011000;
   localparam logic [5:0] FN_MULTU = 6'b011001;
   localparam logic [5:0] FN_DIV   = 6'b011010;
   localparam logic [5:0] FN_DIVU  = 6'b011011;
   localparam logic [5:0] FN_MFHI  = 6'b010000;
   localparam logic [5:0] FN_MTHI  = 6'b010001;
   localparam logic [5:0] FN_MFLO  = 6'b010010;
   localparam logic [5:0] FN_MTLO  = 6'b010011;

   localparam logic [2:0] ALUOP_ADDI = 3'b110;
   localparam logic [2:0] ALUOP_ORI  = 3'b101;
   localparam logic [2:0] ALUOP_ANDI = 3'b011;
   localparam logic [2:0] ALUOP_LUI  = 3'b001;
   localparam logic [2:0] ALUOP_LWSW = 3'b010;
   localparam logic [2:0] ALUOP_BEQ  = 3'b100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } md_state_t;

endpackage

// File: rtl/md_iter_unit.sv
// Iterative multiply (shift-add) / divide (restoring) datapath, one bit per cycle,
// with magnitude conversion on load and sign fix-up of the final result.
module md_iter_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic                  step,
   input  logic                  is_div,
   input  logic                  is_signed,
   input  logic [DATA_WIDTH-1:0] rs,
   input  logic [DATA_WIDTH-1:0] rt,
   output logic                  last,
   output logic [DATA_WIDTH-1:0] res_hi,
   output logic [DATA_WIDTH-1:0] res_lo
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH);

   // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
   logic [2*W-1:0] acc;
   logic [2*W-1:0] acc_next;
   logic [W-1:0]   mag_b;
   logic [W-1:0]   rs_hold;
   logic [CW-1:0]  count;
   logic           div_mode;
   logic           neg_lo;
   logic           neg_hi;
   logic           div_zero;

   logic [W-1:0]   mag_rs;
   logic [W-1:0]   mag_rt;
   logic [W:0]     sum;
   logic [W:0]     shifted;
   logic [W:0]     trial;
   logic [2*W-1:0] prod_fix;
   logic [W-1:0]   quo_fix;
   logic [W-1:0]   rem_fix;

   // operand magnitudes for the signed forms
   always_comb begin
      mag_rs = rs;
      mag_rt = rt;
      if (is_signed && rs[W-1]) begin
         mag_rs = -rs;
      end else begin
         mag_rs = rs;
      end
      if (is_signed && rt[W-1]) begin
         mag_rt = -rt;
      end else begin
         mag_rt = rt;
      end
   end

   // one iteration of shift-add or restoring division
   always_comb begin
      sum      = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mag_b} : {(W+1){1'b0}});
      shifted  = {acc[2*W-1:W], acc[W-1]};
      trial    = shifted - {1'b0, mag_b};
      acc_next = acc;
      if (div_mode) begin
         if (!trial[W]) begin
            acc_next = {trial[W-1:0], acc[W-2:0], 1'b1};
         end else begin
            acc_next = {shifted[W-1:0], acc[W-2:0], 1'b0};
         end
      end else begin
         acc_next = {sum, acc[W-1:1]};
      end
   end

   // sign fix-up and divide-by-zero override of the final result
   always_comb begin
      prod_fix = neg_lo ? -acc_next : acc_next;
      quo_fix  = neg_lo ? -acc_next[W-1:0] : acc_next[W-1:0];
      rem_fix  = neg_hi ? -acc_next[2*W-1:W] : acc_next[2*W-1:W];
      res_hi   = prod_fix[2*W-1:W];
      res_lo   = prod_fix[W-1:0];
      if (div_mode) begin
         if (div_zero) begin
            res_hi = rs_hold;
            res_lo = {W{1'b1}};
         end else begin
            res_hi = rem_fix;
            res_lo = quo_fix;
         end
      end else begin
         res_hi = prod_fix[2*W-1:W];
         res_lo = prod_fix[W-1:0];
      end
   end

   assign last = step && (count == CW'(W-1));

   // operand latch on issue, then one iteration per step cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         acc      <= {(2*W){1'b0}};
         mag_b    <= {W{1'b0}};
         rs_hold  <= {W{1'b0}};
         count    <= {CW{1'b0}};
         div_mode <= 1'b0;
         neg_lo   <= 1'b0;
         neg_hi   <= 1'b0;
         div_zero <= 1'b0;
      end else if (load) begin
         acc      <= {{W{1'b0}}, (is_div ? mag_rs : mag_rt)};
         mag_b    <= is_div ? mag_rt : mag_rs;
         rs_hold  <= rs;
         count    <= {CW{1'b0}};
         div_mode <= is_div;
         neg_lo   <= is_signed && (rs[W-1] ^ rt[W-1]);
         neg_hi   <= is_signed && is_div && rs[W-1];
         div_zero <= is_div && (rt == {W{1'b0}});
      end else if (step) begin
         acc      <= acc_next;
         count    <= count + CW'(1);
      end else begin
         acc      <= acc;
         count    <= count;
      end
   end

endmodule

// File: rtl/alu_control_md.sv
// EX-stage ALU control decoder with HI/LO registers, MFHI/MFLO/MTHI/MTLO and an
// iterative multiply/divide engine that stalls the pipeline while it runs.
module alu_control_md
   import alu_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ALUOP_WIDTH = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   valid_i,
   input  logic [ALUOP_WIDTH-1:0] ALUOp,
   input  logic [5:0]             ALUFunction,
   input  logic [DATA_WIDTH-1:0]  ReadData1,
   input  logic [DATA_WIDTH-1:0]  ReadData2,
   output logic [3:0]             ALUOperation,
   output logic [DATA_WIDTH-1:0]  md_result,
   output logic                   md_result_sel,
   output logic                   stall,
   output logic [DATA_WIDTH-1:0]  hi,
   output logic [DATA_WIDTH-1:0]  lo
);

   md_state_t             state;
   md_state_t             state_next;
   logic                  is_rtype;
   logic                  fn_mul;
   logic                  fn_div;
   logic                  fn_signed;
   logic                  start;
   logic                  busy;
   logic                  last;
   logic                  write_mthi;
   logic                  write_mtlo;
   logic [DATA_WIDTH-1:0] res_hi;
   logic [DATA_WIDTH-1:0] res_lo;

   assign is_rtype  = (ALUOp == {ALUOP_WIDTH{1'b1}});
   assign fn_mul    = is_rtype && (ALUFunction == FN_MULT || ALUFunction == FN_MULTU);
   assign fn_div    = is_rtype && (ALUFunction == FN_DIV  || ALUFunction == FN_DIVU);
   assign fn_signed = (ALUFunction == FN_MULT) || (ALUFunction == FN_DIV);
   assign start     = valid_i && (state == IDLE) && (fn_mul || fn_div);
   assign busy      = (state == MUL) || (state == DIV);
   assign stall     = busy || start;
   assign write_mthi = valid_i && (state == IDLE) && is_rtype && (ALUFunction == FN_MTHI);
   assign write_mtlo = valid_i && (state == IDLE) && is_rtype && (ALUFunction == FN_MTLO);

   // ALU opcode decode
   always_comb begin
      ALUOperation = OP_NONE;
      if (is_rtype) begin
         case (ALUFunction)
            FN_AND:  ALUOperation = OP_AND;
            FN_OR:   ALUOperation = OP_OR;
            FN_ADD:  ALUOperation = OP_ADD;
            FN_SUB:  ALUOperation = OP_SUB;
            FN_NOR:  ALUOperation = OP_NOR;
            FN_SLL:  ALUOperation = OP_SLL;
            FN_SRL:  ALUOperation = OP_SRL;
            FN_JR:   ALUOperation = OP_JR;
            default: ALUOperation = OP_NONE;
         endcase
      end else begin
         case (ALUOp)
            ALUOP_WIDTH'(ALUOP_ADDI): ALUOperation = OP_ADD;
            ALUOP_WIDTH'(ALUOP_ORI):  ALUOperation = OP_OR;
            ALUOP_WIDTH'(ALUOP_ANDI): ALUOperation = OP_AND;
            ALUOP_WIDTH'(ALUOP_LUI):  ALUOperation = OP_LUI;
            ALUOP_WIDTH'(ALUOP_LWSW): ALUOperation = OP_ADD;
            ALUOP_WIDTH'(ALUOP_BEQ):  ALUOperation = OP_SUB;
            default:                  ALUOperation = OP_NONE;
         endcase
      end
   end

   // HI/LO move-from path to write-back
   always_comb begin
      md_result_sel = 1'b0;
      md_result     = {DATA_WIDTH{1'b0}};
      if (is_rtype && ALUFunction == FN_MFHI) begin
         md_result_sel = 1'b1;
         md_result     = hi;
      end else if (is_rtype && ALUFunction == FN_MFLO) begin
         md_result_sel = 1'b1;
         md_result     = lo;
      end else begin
         md_result_sel = 1'b0;
         md_result     = {DATA_WIDTH{1'b0}};
      end
   end

   // next state; DONE always returns to IDLE so a held instruction cannot restart
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start && fn_div) begin
               state_next = DIV;
            end else if (start) begin
               state_next = MUL;
            end else begin
               state_next = IDLE;
            end
         end
         MUL, DIV: begin
            if (last) begin
               state_next = DONE;
            end else begin
               state_next = state;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // HI/LO: engine result on the last iteration, otherwise MTHI/MTLO
   always_ff @(posedge clk) begin
      if (reset) begin
         hi <= {DATA_WIDTH{1'b0}};
         lo <= {DATA_WIDTH{1'b0}};
      end else if (last) begin
         hi <= res_hi;
         lo <= res_lo;
      end else begin
         if (write_mthi) begin
            hi <= ReadData1;
         end else begin
            hi <= hi;
         end
         if (write_mtlo) begin
            lo <= ReadData1;
         end else begin
            lo <= lo;
         end
      end
   end

   md_iter_unit #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_iter (
      .clk       (clk),
      .reset     (reset),
      .load      (start),
      .step      (busy),
      .is_div    (fn_div),
      .is_signed (fn_signed),
      .rs        (ReadData1),
      .rt        (ReadData2),
      .last      (last),
      .res_hi    (res_hi),
      .res_lo    (res_lo)
   );

endmodule

// File: tb/tb_alu_control_md.sv
// Directed-vector bench for alu_control_md: decode sweep, multiply/divide results
// and latency, reset mid-operation, and HI/LO moves.
module tb_alu_control_md;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_i;
   logic [2:0]  ALUOp;
   logic [5:0]  ALUFunction;
   logic [31:0] ReadData1;
   logic [31:0] ReadData2;
   logic [3:0]  ALUOperation;
   logic [31:0] md_result;
   logic        md_result_sel;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;

   int vectors     = 0;
   int miscompares = 0;
   int nstall;

   always #5 clk = ~clk;

   alu_control_md #(.DATA_WIDTH(32), .ALUOP_WIDTH(3)) dut (
      .clk           (clk),
      .reset         (reset),
      .valid_i       (valid_i),
      .ALUOp         (ALUOp),
      .ALUFunction   (ALUFunction),
      .ReadData1     (ReadData1),
      .ReadData2     (ReadData2),
      .ALUOperation  (ALUOperation),
      .md_result     (md_result),
      .md_result_sel (md_result_sel),
      .stall         (stall),
      .hi            (hi),
      .lo            (lo)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic dec(input logic [2:0] op, input logic [5:0] fn, input logic v,
                      input logic [3:0] exp, input string tag);
      @(negedge clk);
      ALUOp = op; ALUFunction = fn; valid_i = v;
      #1;
      check(tag, {60'd0, ALUOperation}, {60'd0, exp});
      check({tag, "_stall"}, {63'd0, stall}, 64'd0);
   endtask

   // issue an R-type mul/div and hold it until stall drops (the DONE cycle)
   task automatic run_md(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                         output int ns);
      @(posedge clk); #1;
      ALUOp = 3'b111; ALUFunction = fn; ReadData1 = a; ReadData2 = b; valid_i = 1'b1;
      ns = 0;
      @(negedge clk);
      while (stall && ns < 100) begin
         ns++;
         @(negedge clk);
      end
   endtask

   initial begin
      reset = 1'b1; valid_i = 1'b0; ALUOp = 3'b000; ALUFunction = 6'b000000;
      ReadData1 = 32'd0; ReadData2 = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_hi", {32'd0, hi}, 64'd0);
      check("rst_lo", {32'd0, lo}, 64'd0);
      check("rst_stall", {63'd0, stall}, 64'd0);
      check("rst_md_result", {32'd0, md_result}, 64'd0);
      reset = 1'b0;

      dec(3'b111, 6'b100100, 1'b1, 4'b0000, "dec_and");
      dec(3'b111, 6'b100101, 1'b1, 4'b0001, "dec_or");
      dec(3'b111, 6'b100000, 1'b1, 4'b0011, "dec_add");
      dec(3'b111, 6'b100010, 1'b1, 4'b0111, "dec_sub");
      dec(3'b111, 6'b100111, 1'b1, 4'b0101, "dec_nor");
      dec(3'b111, 6'b000000, 1'b1, 4'b0100, "dec_sll");
      dec(3'b111, 6'b000010, 1'b1, 4'b0110, "dec_srl");
      dec(3'b111, 6'b001000, 1'b1, 4'b1000, "dec_jr");
      dec(3'b111, 6'b011000, 1'b0, 4'b1001, "dec_mult");
      dec(3'b111, 6'b010000, 1'b1, 4'b1001, "dec_mfhi");
      dec(3'b110, 6'b000000, 1'b1, 4'b0011, "dec_addi");
      dec(3'b101, 6'b000000, 1'b1, 4'b0001, "dec_ori");
      dec(3'b011, 6'b000000, 1'b1, 4'b0000, "dec_andi");
      dec(3'b001, 6'b000000, 1'b1, 4'b0010, "dec_lui");
      dec(3'b010, 6'b000000, 1'b1, 4'b0011, "dec_lwsw");
      dec(3'b100, 6'b000000, 1'b1, 4'b0111, "dec_beq");
      dec(3'b000, 6'b011000, 1'b1, 4'b1001, "dec_op000");
      dec(3'b000, 6'b011000, 1'b1, 4'b1001, "dec_op000_again");
      check("dec_no_write_hi", {32'd0, hi}, 64'd0);
      valid_i = 1'b0;

      // MULT -3 * 5
      run_md(6'b011000, 32'hFFFF_FFFD, 32'd5, nstall);
      check("mult_stall_cycles", 64'(nstall), 64'd33);
      check("mult_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
      check("mult_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFF1);
      @(posedge clk); #1;
      ALUFunction = 6'b010010;
      @(negedge clk);
      check("mflo_result", {32'd0, md_result}, 64'h0000_0000_FFFF_FFF1);
      check("mflo_sel", {63'd0, md_result_sel}, 64'd1);
      check("mflo_stall", {63'd0, stall}, 64'd0);
      ALUFunction = 6'b010000;
      #1;
      check("mfhi_result", {32'd0, md_result}, 64'h0000_0000_FFFF_FFFF);

      // DIVU 100 / 7, then back-to-back DIV -7 / 2
      run_md(6'b011011, 32'd100, 32'd7, nstall);
      check("divu_lo", {32'd0, lo}, 64'd14);
      check("divu_hi", {32'd0, hi}, 64'd2);
      run_md(6'b011010, 32'hFFFF_FFF9, 32'd2, nstall);
      check("div_b2b_stall", 64'(nstall), 64'd33);
      check("div_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFD);
      check("div_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);

      // most-negative / -1
      run_md(6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, nstall);
      check("div_ovf_lo", {32'd0, lo}, 64'h0000_0000_8000_0000);
      check("div_ovf_hi", {32'd0, hi}, 64'd0);

      // DIV 9 / 0
      run_md(6'b011010, 32'd9, 32'd0, nstall);
      check("div0_latency", 64'(nstall + 1), 64'd34);
      check("div0_hi", {32'd0, hi}, 64'd9);
      check("div0_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFF);

      // reset in the middle of a MULT
      @(posedge clk); #1;
      ALUOp = 3'b111; ALUFunction = 6'b011000; ReadData1 = 32'd5; ReadData2 = 32'd3;
      valid_i = 1'b1;
      repeat (11) @(posedge clk);
      #1;
      check("mid_mult_stall", {63'd0, stall}, 64'd1);
      reset = 1'b1; valid_i = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("midrst_stall", {63'd0, stall}, 64'd0);
      check("midrst_hi", {32'd0, hi}, 64'd0);
      check("midrst_lo", {32'd0, lo}, 64'd0);
      repeat (40) @(negedge clk);
      check("midrst_no_late_write", {hi, lo}, 64'd0);
      check("midrst_idle_stall", {63'd0, stall}, 64'd0);

      // MULTU 0xFFFFFFFF * 2
      run_md(6'b011001, 32'hFFFF_FFFF, 32'd2, nstall);
      check("multu_stall_cycles", 64'(nstall), 64'd33);
      check("multu_hi", {32'd0, hi}, 64'd1);
      check("multu_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFE);

      // MTLO then MFLO
      @(posedge clk); #1;
      ALUFunction = 6'b010011; ReadData1 = 32'h0000_1234; valid_i = 1'b1;
      @(negedge clk);
      check("mtlo_stall", {63'd0, stall}, 64'd0);
      @(posedge clk); #1;
      ALUFunction = 6'b010010;
      @(negedge clk);
      check("mtlo_mflo_result", {32'd0, md_result}, 64'h0000_0000_0000_1234);
      check("mtlo_mflo_sel", {63'd0, md_result_sel}, 64'd1);
      check("mtlo_hi_kept", {32'd0, hi}, 64'd1);

      // MTHI with valid_i low must not write
      @(posedge clk); #1;
      ALUFunction = 6'b010001; ReadData1 = 32'h0000_DEAD; valid_i = 1'b0;
      @(posedge clk); #1;
      ALUFunction = 6'b010000; valid_i = 1'b1;
      @(negedge clk);
      check("mthi_invalid_hi", {32'd0, hi}, 64'd1);
      check("mthi_invalid_mfhi", {32'd0, md_result}, 64'd1);

      // non-move funct gives zero md_result
      ALUFunction = 6'b100000;
      #1;
      check("add_md_result", {32'd0, md_result}, 64'd0);
      check("add_md_sel", {63'd0, md_result_sel}, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
